// File: rtl/demux_dist8.sv
// Registered 1:2 distributor: one valid/ready input stream steered by SEL into
// one-entry holding slots A or B, each with its own completed-transfer counter.
module demux_dist8 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D_IN,
  input  logic             D_VALID,
  output logic             D_READY,
  input  logic             SEL,
  output logic [WIDTH-1:0] A,
  output logic             A_VALID,
  input  logic             A_READY,
  output logic [WIDTH-1:0] B,
  output logic             B_VALID,
  input  logic             B_READY,
  output logic [CNT_W-1:0] CNT_A,
  output logic [CNT_W-1:0] CNT_B
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_t;

  slot_t state_a;
  slot_t state_b;
  logic  slot_rdy_a;
  logic  slot_rdy_b;
  logic  acc;
  logic  acc_a;
  logic  acc_b;

  // Counters wrap silently at 2^CNT_W.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] one;
    one = '0;
    one[0] = 1'b1;
    return c + one;
  endfunction

  // A slot can take a word when empty or when its current word leaves this cycle;
  // only the addressed slot decides, so a stalled slot never blocks the other.
  assign slot_rdy_a = (state_a == EMPTY) || A_READY;
  assign slot_rdy_b = (state_b == EMPTY) || B_READY;
  assign D_READY    = SEL ? slot_rdy_b : slot_rdy_a;

  assign acc   = D_VALID & D_READY;
  assign acc_a = acc & ~SEL;
  assign acc_b = acc & SEL;

  assign A_VALID = (state_a == FULL);
  assign B_VALID = (state_b == FULL);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_a <= EMPTY;
      state_b <= EMPTY;
      A       <= '0;
      B       <= '0;
      CNT_A   <= '0;
      CNT_B   <= '0;
    end else begin
      case (state_a)
        EMPTY:   if (acc_a) state_a <= FULL;
        FULL:    if (A_READY && !acc_a) state_a <= EMPTY;
        default: state_a <= EMPTY;
      endcase
      case (state_b)
        EMPTY:   if (acc_b) state_b <= FULL;
        FULL:    if (B_READY && !acc_b) state_b <= EMPTY;
        default: state_b <= EMPTY;
      endcase

      // Data is only replaced on accept, so it persists after a drain.
      if (acc_a) A <= D_IN;
      if (acc_b) B <= D_IN;

      if (A_VALID && A_READY) CNT_A <= cnt_inc(CNT_A);
      if (B_VALID && B_READY) CNT_B <= cnt_inc(CNT_B);
    end
  end

endmodule

// File: tb/tb_demux_dist8.sv
// Bench for demux_dist8: slot-level reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_demux_dist8;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic             CLK = 1'b0;
  logic             RST;
  logic [WIDTH-1:0] D_IN;
  logic             D_VALID;
  logic             D_READY;
  logic             SEL;
  logic [WIDTH-1:0] A;
  logic             A_VALID;
  logic             A_READY;
  logic [WIDTH-1:0] B;
  logic             B_VALID;
  logic             B_READY;
  logic [CNT_W-1:0] CNT_A;
  logic [CNT_W-1:0] CNT_B;

  demux_dist8 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .D_IN(D_IN), .D_VALID(D_VALID), .D_READY(D_READY), .SEL(SEL),
    .A(A), .A_VALID(A_VALID), .A_READY(A_READY),
    .B(B), .B_VALID(B_VALID), .B_READY(B_READY),
    .CNT_A(CNT_A), .CNT_B(CNT_B)
  );

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: slot index 0 = A, 1 = B.
  bit          m_full [2];
  logic [7:0]  m_data [2];
  int unsigned m_cnt  [2];
  bit          m_rdy  [2];
  bit          m_acc;
  int          m_s;

  always @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < 2; k++) begin
        m_full[k] = 1'b0;
        m_data[k] = 8'h00;
        m_cnt[k]  = 0;
      end
    end else begin
      m_rdy[0] = A_READY;
      m_rdy[1] = B_READY;
      m_s      = SEL ? 1 : 0;
      m_acc    = D_VALID && (!m_full[m_s] || m_rdy[m_s]);
      for (int k = 0; k < 2; k++) begin
        if (m_full[k] && m_rdy[k]) begin
          m_cnt[k]  = (m_cnt[k] + 1) % (1 << CNT_W);
          m_full[k] = 1'b0;
        end
      end
      if (m_acc) begin
        m_full[m_s] = 1'b1;
        m_data[m_s] = D_IN;
      end
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("A_VALID", 32'(A_VALID), 32'(m_full[0]));
      chk("B_VALID", 32'(B_VALID), 32'(m_full[1]));
      chk("A", 32'(A), 32'(m_data[0]));
      chk("B", 32'(B), 32'(m_data[1]));
      chk("CNT_A", 32'(CNT_A), m_cnt[0]);
      chk("CNT_B", 32'(CNT_B), m_cnt[1]);
      chk("D_READY", 32'(D_READY),
          32'(SEL ? (!m_full[1] || B_READY) : (!m_full[0] || A_READY)));
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; D_VALID = 1'b1; D_IN = 8'hFF; SEL = 1'b0;
    A_READY = 1'b0; B_READY = 1'b0;

    // 1. reset held for two edges with D_VALID high
    step(); step();
    chk("rst A_VALID", 32'(A_VALID), 32'd0);
    chk("rst B_VALID", 32'(B_VALID), 32'd0);
    chk("rst A", 32'(A), 32'd0);
    chk("rst B", 32'(B), 32'd0);
    chk("rst CNT_A", 32'(CNT_A), 32'd0);
    chk("rst CNT_B", 32'(CNT_B), 32'd0);
    RST = 1'b0; D_VALID = 1'b0;
    #1;
    chk("rst D_READY", 32'(D_READY), 32'd1);
    cmp_en = 1'b1;

    // 2. routing
    A_READY = 1'b1; B_READY = 1'b1;
    D_IN = 8'hAA; SEL = 1'b0; D_VALID = 1'b1;
    step();
    chk("route A", 32'(A), 32'hAA);
    chk("route A_VALID", 32'(A_VALID), 32'd1);
    D_IN = 8'h55; SEL = 1'b1;
    step();
    D_VALID = 1'b0;
    chk("route B", 32'(B), 32'h55);
    chk("route B_VALID", 32'(B_VALID), 32'd1);
    chk("route A drained", 32'(A_VALID), 32'd0);
    chk("route CNT_A", 32'(CNT_A), 32'd1);
    step();
    chk("route CNT_B", 32'(CNT_B), 32'd1);
    chk("route B drained", 32'(B_VALID), 32'd0);
    chk("route A persists", 32'(A), 32'hAA);

    // 3. backpressure on A, B independent
    A_READY = 1'b0; B_READY = 1'b0;
    D_IN = 8'h11; SEL = 1'b0; D_VALID = 1'b1;
    step();
    D_IN = 8'h22;
    #1;
    chk("bp D_READY stalled", 32'(D_READY), 32'd0);
    step();
    chk("bp A held", 32'(A), 32'h11);
    SEL = 1'b1; D_IN = 8'h33;
    #1;
    chk("bp D_READY to B", 32'(D_READY), 32'd1);
    step();
    chk("bp B", 32'(B), 32'h33);
    chk("bp A still 11", 32'(A), 32'h11);
    SEL = 1'b0; D_IN = 8'h22; A_READY = 1'b1;
    #1;
    chk("bp D_READY drain", 32'(D_READY), 32'd1);
    step();
    chk("bp A replaced", 32'(A), 32'h22);
    chk("bp A_VALID", 32'(A_VALID), 32'd1);
    chk("bp CNT_A", 32'(CNT_A), 32'd2);
    D_VALID = 1'b0;
    step();
    chk("bp CNT_A drain", 32'(CNT_A), 32'd3);
    chk("bp B stalled", 32'(B_VALID), 32'd1);
    // SEL toggling while stalled must not route anything
    D_VALID = 1'b1; SEL = 1'b1; D_IN = 8'h77;
    step();
    SEL = 1'b0; D_IN = 8'h78; A_READY = 1'b0;
    step();
    D_VALID = 1'b0;
    chk("bp B unchanged", 32'(B), 32'h33);
    chk("bp A took 78", 32'(A), 32'h78);

    // 6. mid-op reset with both slots full and stalled
    A_READY = 1'b0; B_READY = 1'b0;
    step();
    chk("mid A_VALID pre", 32'(A_VALID), 32'd1);
    chk("mid B_VALID pre", 32'(B_VALID), 32'd1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("mid A_VALID", 32'(A_VALID), 32'd0);
    chk("mid B_VALID", 32'(B_VALID), 32'd0);
    chk("mid CNT_A", 32'(CNT_A), 32'd0);
    chk("mid CNT_B", 32'(CNT_B), 32'd0);

    // 4. streaming into A
    A_READY = 1'b1; SEL = 1'b0; D_VALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      D_IN = 8'(8'h40 + i);
      step();
      chk("stream A", 32'(A), 32'(8'h40 + i));
      chk("stream A_VALID", 32'(A_VALID), 32'd1);
    end
    D_VALID = 1'b0;
    step();
    chk("stream CNT_A", 32'(CNT_A), 32'd20);

    // 5. counter wrap on B
    B_READY = 1'b1; SEL = 1'b1; D_VALID = 1'b1;
    for (int i = 0; i < 256; i++) begin
      D_IN = 8'(i);
      step();
    end
    chk("wrap CNT_B 255", 32'(CNT_B), 32'd255);
    D_VALID = 1'b0;
    step();
    chk("wrap CNT_B 0", 32'(CNT_B), 32'd0);

    // mixed traffic checked by the model only
    for (int i = 0; i < 300; i++) begin
      D_IN    = 8'($urandom_range(0, 255));
      D_VALID = 1'($urandom_range(0, 1));
      SEL     = 1'($urandom_range(0, 1));
      A_READY = 1'($urandom_range(0, 1));
      B_READY = 1'($urandom_range(0, 1));
      RST     = ($urandom_range(0, 63) == 0);
      step();
    end
    RST = 1'b0;
    step();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
